// File: rtl/io_pkg.sv
// Shared types and constants for the board I/O controller: input FSM states,
// active-low 7-segment glyphs (bit order gfedcba) and BCD sizing helper.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } in_state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

  // Enough decimal digits for any unsigned data_w-bit value.
  function automatic int bcd_digits(input int data_w);
    return data_w / 3 + 1;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Button debouncer: 2-flop synchroniser, then btn_db follows the synchronised
// level once it has differed for DB_CYCLES consecutive cycles. No backpressure.
module io_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_db
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt_q   <= '0;
      btn_db  <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      // Any cycle that agrees with the accepted level restarts the count.
      if (sync_q2 == btn_db) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        btn_db <= sync_q2;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_ctrl.sv
// Board I/O: debounced enter-button input handshake (stall until press+release) and 7-segment
// display; decimal double-dabble (DATA_W+1 cycles), or 1-cycle hex when IO_HEX_DISPLAY_EN is defined.
module io_ctrl
  import io_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SW_W      = 16,
  parameter int DIGITS    = 8,
  parameter int DB_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn,
  input  logic [SW_W-1:0]       switches,
  input  logic                  in_req,
  output logic                  in_stall,
  output logic                  in_valid,
  output logic [DATA_W-1:0]     in_data,
  input  logic                  out_we,
  input  logic [DATA_W-1:0]     out_data,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  disp_busy,
  output logic                  disp_ovf
);

  // ---------------- input handshake ----------------
  logic      btn_db;
  logic      capture;
  in_state_t state_q;
  in_state_t state_nxt;

  io_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .btn_db (btn_db)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    capture   = 1'b0;
    in_valid  = 1'b0;
    in_stall  = in_req && (state_q != DONE);
    unique case (state_q)
      // A press already held when the request arrives must be released first.
      IDLE: if (in_req && !btn_db) state_nxt = WAIT_PRESS;
      WAIT_PRESS: begin
        if (!in_req) begin
          state_nxt = IDLE;
        end else if (btn_db) begin
          capture   = 1'b1;
          state_nxt = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!in_req)     state_nxt = IDLE;
        else if (!btn_db) state_nxt = DONE;
      end
      DONE: begin
        in_valid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)        in_data <= '0;
    else if (capture) in_data <= DATA_W'($signed(switches));
  end

  // ---------------- display ----------------
  logic [7*DIGITS-1:0] seg_nxt;
  logic                ovf_nxt;

`ifdef IO_HEX_DISPLAY_EN
  localparam int NIB_N = (DATA_W + 3) / 4;
  localparam int HEX_N = (NIB_N > DIGITS) ? NIB_N : DIGITS;

  logic [4*HEX_N-1:0] nib_pad;

  always_comb begin
    nib_pad               = '0;
    nib_pad[DATA_W-1:0]   = out_data;
    seg_nxt               = '0;
    ovf_nxt               = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_nxt[7*i +: 7] = seg_glyph(nib_pad[4*i +: 4]);
    end
    for (int i = DIGITS; i < HEX_N; i++) begin
      if (nib_pad[4*i +: 4] != 4'd0) ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg      <= {DIGITS{SEG_BLANK}};
      seg[6:0] <= SEG_0;
      disp_ovf <= 1'b0;
    end else if (out_we) begin
      seg      <= seg_nxt;
      disp_ovf <= ovf_nxt;
    end
  end

  assign disp_busy = 1'b0;
`else
  localparam int BCD_N = bcd_digits(DATA_W);
  localparam int PAD_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]  bin_q;
  logic [4*BCD_N-1:0] bcd_q;
  logic [4*BCD_N-1:0] bcd_adj;
  logic [4*PAD_N-1:0] bcd_pad;
  logic [CNT_W-1:0]   cnt_q;
  logic               lead;

  // Double-dabble correction: any digit >= 5 gets +3 before the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bcd_pad              = '0;
    bcd_pad[4*BCD_N-1:0] = bcd_q;
    seg_nxt              = '0;
    ovf_nxt              = 1'b0;
    for (int i = DIGITS; i < PAD_N; i++) begin
      if (bcd_pad[4*i +: 4] != 4'd0) ovf_nxt = 1'b1;
    end
    // Zeros are leading only while every more-significant digit is zero too.
    lead = !ovf_nxt;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd_pad[4*i +: 4] != 4'd0) lead = 1'b0;
      seg_nxt[7*i +: 7] = (lead && i != 0) ? SEG_BLANK : seg_glyph(bcd_pad[4*i +: 4]);
    end
  end

  // The write cycle also performs the first shift; cnt_q counts shifts done.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      disp_busy <= 1'b0;
      disp_ovf  <= 1'b0;
      seg       <= {DIGITS{SEG_BLANK}};
      seg[6:0]  <= SEG_0;
    end else if (out_we) begin
      bin_q     <= out_data << 1;
      bcd_q     <= (4*BCD_N)'(out_data[DATA_W-1]);
      cnt_q     <= CNT_W'(1);
      disp_busy <= 1'b1;
    end else if (disp_busy) begin
      if (cnt_q == CNT_W'(DATA_W)) begin
        seg       <= seg_nxt;
        disp_ovf  <= ovf_nxt;
        disp_busy <= 1'b0;
      end else begin
        bcd_q <= (4*BCD_N)'({bcd_adj, bin_q[DATA_W-1]});
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: display vector table plus random values against an
// arithmetic model, and hand-written button/handshake sequences with DB_CYCLES=4.
module tb_io_ctrl;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int DIGITS = 8;
  localparam int DB     = 4;
`ifdef IO_HEX_DISPLAY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = DATA_W + 1;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                btn;
  logic [SW_W-1:0]     switches;
  logic                in_req;
  logic                in_stall;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                out_we;
  logic [DATA_W-1:0]   out_data;
  logic [7*DIGITS-1:0] seg;
  logic                disp_busy;
  logic                disp_ovf;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int low_stall   = 0;
  int low_stall_v = 0;
  bit win         = 1'b0;
  logic [DATA_W-1:0]   pulse_data = '0;
  logic [7*DIGITS-1:0] shown;
  logic [7*DIGITS-1:0] reset_seg;

  typedef struct {
    logic [31:0] val;
    logic        ovf;
  } disp_vec_t;
  disp_vec_t tbl [9];

  io_ctrl #(
    .DATA_W(DATA_W), .SW_W(SW_W), .DIGITS(DIGITS), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .switches(switches),
    .in_req(in_req), .in_stall(in_stall), .in_valid(in_valid), .in_data(in_data),
    .out_we(out_we), .out_data(out_data), .seg(seg),
    .disp_busy(disp_busy), .disp_ovf(disp_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // Samples outputs mid-cycle, away from the rising edge.
  task automatic tick();
    @(negedge clk);
    if (in_valid === 1'b1) begin
      pulses++;
      pulse_data = in_data;
    end
    if (win && in_stall !== 1'b1) begin
      low_stall++;
      if (in_valid === 1'b1) low_stall_v++;
    end
  endtask

  task automatic hold_btn(input logic lvl, input int n);
    btn = lvl;
    repeat (n) tick();
  endtask

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] lit [16];
    lit = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return ~lit[d];
  endfunction

  function automatic logic [7*DIGITS-1:0] model_seg(input logic [31:0] v);
    logic [7*DIGITS-1:0] s;
    longint unsigned x;
    longint unsigned p;
    s = '0;
    x = 64'(v);
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef IO_HEX_DISPLAY_EN
      s[7*i +: 7] = glyph(int'((x >> (4*i)) & 64'd15));
`else
      if (i == 0 || x >= p) s[7*i +: 7] = glyph(int'((x / p) % 64'd10));
      else                  s[7*i +: 7] = 7'h7F;
      p = p * 10;
`endif
    end
    return s;
  endfunction

  function automatic logic model_ovf(input logic [31:0] v);
`ifdef IO_HEX_DISPLAY_EN
    return (v != v);
`else
    return (64'(v) >= 64'd100000000);
`endif
  endfunction

  task automatic run_display(input string name, input logic [31:0] v, input logic exp_ovf);
    int busy_n = 0;
    int drift  = 0;
    out_we   = 1'b1;
    out_data = v;
    for (int k = 0; k < LAT; k++) begin
      tick();
      out_we = 1'b0;
      if (disp_busy === 1'b1) busy_n++;
      if (k < LAT - 1 && seg !== shown) drift++;
    end
    check({name, " busy_cycles"}, 64'(busy_n), 64'(LAT - 1));
    check({name, " hold"}, 64'(drift), 64'd0);
    check({name, " seg"}, 64'(seg), 64'(model_seg(v)));
    check({name, " ovf"}, 64'(disp_ovf), 64'(exp_ovf));
    shown = model_seg(v);
  endtask

  task automatic check_reset_state(input string name);
    check({name, " in_stall"}, 64'(in_stall), 64'd0);
    check({name, " in_valid"}, 64'(in_valid), 64'd0);
    check({name, " in_data"}, 64'(in_data), 64'd0);
    check({name, " disp_busy"}, 64'(disp_busy), 64'd0);
    check({name, " disp_ovf"}, 64'(disp_ovf), 64'd0);
    check({name, " seg"}, 64'(seg), 64'(reset_seg));
  endtask

  initial begin
    logic [SW_W-1:0] sw;
    logic [31:0]     v;
    reset_seg = {{(DIGITS-1){7'h7F}}, glyph(0)};
    tbl = '{
      '{32'd1234,        1'b0}, '{32'd0,          1'b0}, '{32'd7,          1'b0},
      '{32'd10,          1'b0}, '{32'd99999999,   1'b0}, '{32'd100000000,  1'b1},
      '{32'd4294967295,  1'b1}, '{32'd1000000000, 1'b1}, '{32'hDEADBEEF,   1'b1}
    };

    reset = 1'b1; btn = 1'b0; switches = '0; in_req = 1'b0;
    out_we = 1'b0; out_data = '0;
    repeat (3) tick();
    check_reset_state("reset");
    reset = 1'b0;
    shown = reset_seg;
    tick();

    // Display vector table.
    for (int i = 0; i < 9; i++) begin
`ifdef IO_HEX_DISPLAY_EN
      run_display($sformatf("tbl%0d", i), tbl[i].val, model_ovf(tbl[i].val));
`else
      run_display($sformatf("tbl%0d", i), tbl[i].val, tbl[i].ovf);
`endif
    end

    // Random display values.
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? $urandom : $urandom_range(0, 99999);
      run_display($sformatf("rnd%0d", i), v, model_ovf(v));
    end

    // Rewrite while busy: the first value must never reach the display.
    begin
      int drift = 0;
      out_we = 1'b1; out_data = 32'd5;
      for (int k = 0; k < 10; k++) begin
        tick();
        out_we = 1'b0;
        if (seg !== shown) drift++;
      end
      check("restart first_value_hidden", 64'(drift), 64'd0);
      run_display("restart77", 32'd77, 1'b0);
    end

    // Glitches shorter than DB are ignored; a 6-cycle press is one input.
    switches = 16'h8005; in_req = 1'b1;
    pulses = 0; low_stall = 0; low_stall_v = 0; win = 1'b1;
    tick();
    hold_btn(1'b1, 1); hold_btn(1'b0, 1); hold_btn(1'b1, 1); hold_btn(1'b0, 3);
    check("glitch no_pulse", 64'(pulses), 64'd0);
    hold_btn(1'b1, 6);
    hold_btn(1'b0, 20);
    win = 1'b0;
    check("press pulses", 64'(pulses), 64'd1);
    check("press in_data", 64'(pulse_data), 64'h00000000FFFF8005);
    check("press stall_low_cycles", 64'(low_stall), 64'd1);
    check("press stall_low_with_valid", 64'(low_stall_v), 64'd1);
    in_req = 1'b0;
    tick();

    // Button already held when the request arrives.
    hold_btn(1'b1, 10);
    in_req = 1'b1; pulses = 0;
    repeat (10) tick();
    check("held no_pulse", 64'(pulses), 64'd0);
    check("held stall", 64'(in_stall), 64'd1);
    switches = 16'h1234;
    hold_btn(1'b0, 10);
    check("held release no_pulse", 64'(pulses), 64'd0);
    switches = 16'h7ABC;
    hold_btn(1'b1, DB + 3);
    switches = 16'hFFFF;
    hold_btn(1'b0, 20);
    check("repress pulses", 64'(pulses), 64'd1);
    check("repress in_data", 64'(pulse_data), 64'h0000000000007ABC);
    in_req = 1'b0;
    tick();

    // Press one cycle shorter than the debounce window never registers.
    in_req = 1'b1; pulses = 0;
    tick();
    hold_btn(1'b1, DB - 1);
    hold_btn(1'b0, 15);
    check("short_press no_pulse", 64'(pulses), 64'd0);
    switches = 16'h0042;
    hold_btn(1'b1, DB + 3);
    hold_btn(1'b0, 20);
    check("min_press pulses", 64'(pulses), 64'd1);
    in_req = 1'b0;
    tick();

    // Request withdrawn while the button is down: no pulse.
    in_req = 1'b1; pulses = 0;
    tick();
    hold_btn(1'b1, DB + 4);
    in_req = 1'b0;
    hold_btn(1'b0, 15);
    check("withdraw no_pulse", 64'(pulses), 64'd0);

    // Random press/release sessions against a press-count model.
    for (int s = 0; s < 6; s++) begin
      sw = SW_W'($urandom);
      switches = sw; in_req = 1'b1; pulses = 0;
      repeat ($urandom_range(1, 4)) tick();
      hold_btn(1'b1, DB + 3 + int'($urandom_range(0, 4)));
      switches = ~sw;
      hold_btn(1'b0, 3 * DB + 6);
      check($sformatf("sess%0d pulses", s), 64'(pulses), 64'd1);
      check($sformatf("sess%0d in_data", s), 64'(pulse_data),
            64'({{(DATA_W-SW_W){sw[SW_W-1]}}, sw}));
      in_req = 1'b0;
      repeat (2) tick();
    end

    // Reset in WAIT_RELEASE and mid-conversion.
    switches = 16'h00F0; in_req = 1'b1;
    tick();
    hold_btn(1'b1, DB + 6);
    out_we = 1'b1; out_data = 32'd4321;
    tick();
    out_we = 1'b0;
    repeat (9) tick();
    reset = 1'b1; in_req = 1'b0; pulses = 0;
    tick();
    check_reset_state("midreset");
    reset = 1'b0; btn = 1'b0;
    repeat (40) tick();
    check("midreset no_pulse", 64'(pulses), 64'd0);
    check("midreset seg_stays", 64'(seg), 64'(reset_seg));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
